counter_update_ctrl: RTL and testbench
======================================

Name: counter_update_ctrl

Overview:
- Read-modify-write controller for the 256x3 counter_array SRAM (1W/1R) that holds the per-set mutation counters of the mutative cache.
- Accepts one counter operation per cycle from the cache controller: increment, decrement or clear.
- Reads the counter via SRAM port 1 and writes the saturated result via SRAM port 0.
- Returns the new value and a mutate flag. Sweeps the array to a known value after reset.

Parameters:
- DATA_WIDTH, 3, counter width; must match the SRAM word.
- ADDR_WIDTH, 8, set index width; SRAM depth is 1<<ADDR_WIDTH.
- INIT_VALUE, 0, value written to every entry during the init sweep.
- MUTATE_THRESH, 6, resp_mutate asserts when the new value >= this.

Ports:
- clk  in  1  clock; also drives SRAM clk0/clk1.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  high when a request can be accepted (equals init_done).
- req_set  in  ADDR_WIDTH  set index.
- req_op  in  2  01 inc, 10 dec, 11 clear, 00 read-only (no write).
- resp_valid  out  1  result valid for one cycle.
- resp_set  out  ADDR_WIDTH  set index of the result.
- resp_count  out  DATA_WIDTH  updated counter value.
- resp_mutate  out  1  resp_count >= MUTATE_THRESH.
- resp_sat  out  1  inc at max or dec at 0 (value unchanged).
- init_done  out  1  init sweep complete.
- sram_csb0  out  1  SRAM write chip select, active low.
- sram_addr0  out  ADDR_WIDTH  SRAM write address.
- sram_din0  out  DATA_WIDTH  SRAM write data.
- sram_csb1  out  1  SRAM read chip select, active low.
- sram_addr1  out  ADDR_WIDTH  SRAM read address.
- sram_dout1  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset values: req_ready=0, init_done=0, resp_valid=0, resp_set=0, resp_count=0, resp_mutate=0, resp_sat=0, sram_csb0=1, sram_csb1=1, init pointer=0. State goes to INIT.
- FSM INIT: each cycle drives csb0=0, addr0=ptr, din0=INIT_VALUE, then ptr++. After the write at ptr=255 is driven, go to RUN; init_done=1 from the next cycle. The sweep takes 256 cycles, with no reads.
- FSM RUN: req_ready=1. Accept when req_valid&req_ready in cycle N.
- Cycle N: sram_csb1=0, sram_addr1=req_set (combinational). Stage-1 register captures set/op at the posedge.
- Cycle N+1: old value = forwarded data if the forward hit, else sram_dout1.
  - inc: min(old+1, 2^DATA_WIDTH-1).
  - dec: max(old-1, 0).
  - clear: 0.
  - read-only: old.
  - For any op other than 00, drive csb0=0, addr0=set, din0=new in the same cycle.
- Cycle N+2: resp_valid=1 with set/count/mutate/sat. Latency is 2 cycles; throughput is 1/cycle; no response backpressure.
- Forwarding: a 1-entry register holds the last driven write (valid, addr, data), including init writes. If stage-1 set equals that addr while valid, use its data instead of sram_dout1.
  - This covers the same-negedge write/read race of the SRAM.
  - Writes two or more cycles older are already in the array.
- csb1 is kept high when no request is accepted; csb0 is kept high when no write is driven.
- Arithmetic: DATA_WIDTH-wide unsigned; saturation is detected before the update.
- rst asserted mid-operation: the pipeline is flushed, the in-flight write is dropped (csb0=1 immediately), the FSM returns to INIT, and the sweep restarts at 0.

Optional Feature:
- Macro: CNT_SAT_STATS_EN.
- Defined: adds output sat_events (16 bits). It increments on every resp_sat pulse, saturates at 0xFFFF, and clears on rst.
- Not defined: the port and the counter are absent.

Test Plan:
- Reset, then idle: 256 writes with din=INIT_VALUE, addr 0..255; init_done rises at cycle 257; no csb1 activity during the sweep.
- Single inc on set 0x12 after init: resp_valid 2 cycles later; resp_count=1, mutate=0, sat=0; SRAM write addr0=0x12, din0=1.
- Seven back-to-back incs on set 0x40: resp_count 1,2,3,4,5,6,7 on consecutive cycles (forwarding exercised); mutate=1 from value 6; an 8th inc gives count=7, sat=1.
- Dec on a freshly initialised set 0x05: count=0, sat=1. Clear on set 0x40 (value 7): count=0, write din0=0.
- Interleaved sets A,B,A,B with inc: each count advances independently (1,1,2,2); no false forward hit.
- Assert rst during a burst: csb0/csb1 go high immediately, resp_valid=0, the sweep restarts at addr 0, and a post-init read of a previously incremented set returns INIT_VALUE.

Source files
------------

// File: rtl/counter_update_ctrl.sv
// counter_update_ctrl: read-modify-write controller for the per-set mutation
// counter SRAM (1W/1R). After reset it sweeps every entry to INIT_VALUE. It then
// accepts one inc/dec/clear/read-only operation per cycle and returns the
// saturated new value two cycles after acceptance.
//
// Ports:
//   clk, rst                 clock (also clocks the SRAM); async active-high reset
//   req_valid/ready/set/op   request handshake (op: 01 inc, 10 dec, 11 clear, 00 read)
//   resp_valid/set/count     one-cycle result pulse with the updated value
//   resp_mutate, resp_sat    count >= MUTATE_THRESH; inc at max / dec at zero
//   init_done                init sweep finished
//   sram_csb0/addr0/din0     SRAM write port (combinational, csb active low)
//   sram_csb1/addr1/dout1    SRAM read port (combinational request, data next cycle)
//   sat_events               16-bit saturating count of resp_sat pulses
//                            (present only when CNT_SAT_STATS_EN is defined)
//
// Optional feature macro: CNT_SAT_STATS_EN
module counter_update_ctrl #(
  parameter int unsigned DATA_WIDTH    = 3,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned INIT_VALUE    = 0,
  parameter int unsigned MUTATE_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_set,
  input  logic [1:0]            req_op,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_set,
  output logic [DATA_WIDTH-1:0] resp_count,
  output logic                  resp_mutate,
  output logic                  resp_sat,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef CNT_SAT_STATS_EN
  ,
  output logic [15:0]           sat_events
`endif
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(INIT_VALUE);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_ptr;

  logic                    s1_valid;
  logic [ADDR_WIDTH-1:0]   s1_set;
  logic [1:0]              s1_op;

  logic                    fwd_valid;
  logic [ADDR_WIDTH-1:0]   fwd_addr;
  logic [DATA_WIDTH-1:0]   fwd_data;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   old_count;
  logic [DATA_WIDTH-1:0]   new_count;
  logic                    sat;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  assign req_ready = init_done;

  // Stage-1 update and SRAM port drive. Port signals are gated by rst so an
  // in-flight write is dropped the moment reset asserts.
  always_comb begin
    accept    = req_valid & init_done;
    // The previous cycle's write races the read in the array; take it from the bypass.
    old_count = (fwd_valid && (fwd_addr == s1_set)) ? fwd_data : sram_dout1;
    new_count = old_count;
    sat       = 1'b0;
    case (s1_op)
      OP_INC: begin
        if (old_count == CNT_MAX) sat = 1'b1;
        else                      new_count = old_count + 1'b1;
      end
      OP_DEC: begin
        if (old_count == '0) sat = 1'b1;
        else                 new_count = old_count - 1'b1;
      end
      OP_CLR:  new_count = '0;
      default: new_count = old_count;
    endcase

    wr_en   = 1'b0;
    wr_addr = s1_set;
    wr_data = new_count;
    if (!rst) begin
      if (state == ST_INIT) begin
        wr_en   = 1'b1;
        wr_addr = init_ptr;
        wr_data = INIT_VAL;
      end else if (s1_valid && (s1_op != OP_READ)) begin
        wr_en   = 1'b1;
      end
    end

    sram_csb0  = ~wr_en;
    sram_addr0 = wr_addr;
    sram_din0  = wr_data;
    sram_csb1  = ~(accept & ~rst);
    sram_addr1 = req_set;
  end

  // FSM, pipeline, bypass register and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      init_ptr    <= '0;
      init_done   <= 1'b0;
      s1_valid    <= 1'b0;
      s1_set      <= '0;
      s1_op       <= OP_READ;
      fwd_valid   <= 1'b0;
      fwd_addr    <= '0;
      fwd_data    <= '0;
      resp_valid  <= 1'b0;
      resp_set    <= '0;
      resp_count  <= '0;
      resp_mutate <= 1'b0;
      resp_sat    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == PTR_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_set <= req_set;
        s1_op  <= req_op;
      end

      if (wr_en) begin
        fwd_valid <= 1'b1;
        fwd_addr  <= wr_addr;
        fwd_data  <= wr_data;
      end

      resp_valid  <= s1_valid;
      resp_sat    <= s1_valid & sat;
      resp_mutate <= s1_valid & (32'(new_count) >= MUTATE_THRESH);
      if (s1_valid) begin
        resp_set   <= s1_set;
        resp_count <= new_count;
      end
    end
  end

`ifdef CNT_SAT_STATS_EN
  // Saturating tally of saturation responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_events <= '0;
    end else if (resp_sat && (sat_events != 16'hFFFF)) begin
      sat_events <= sat_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_update_ctrl.sv
// Bench for counter_update_ctrl: a read-first SRAM model, a sequential reference
// of the counters (updated in request order), directed scenarios and a random burst.
module tb_counter_update_ctrl;

  localparam int unsigned DW    = 3;
  localparam int unsigned AW    = 8;
  localparam int          DEPTH = 256;
  localparam int          INITV = 0;
  localparam int          THR   = 6;
  localparam int          CMAX  = 7;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_set;
  logic [1:0]    req_op;
  logic          resp_valid;
  logic [AW-1:0] resp_set;
  logic [DW-1:0] resp_count;
  logic          resp_mutate;
  logic          resp_sat;
  logic          init_done;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;
`ifdef CNT_SAT_STATS_EN
  logic [15:0]   sat_events;
`endif

  counter_update_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INITV), .MUTATE_THRESH(THR)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_op(req_op),
    .resp_valid(resp_valid), .resp_set(resp_set), .resp_count(resp_count),
    .resp_mutate(resp_mutate), .resp_sat(resp_sat), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef CNT_SAT_STATS_EN
    , .sat_events(sat_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first SRAM: a read and a write to the same address at one edge returns old data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit v;
    int set;
    int op;
    int newv;
    bit mut;
    bit sat;
  } ent_t;

  int   cnt_m [DEPTH];
  int   init_cnt;
  int   sat_ev_m;
  ent_t d1, d2;
  int   q_cnt[$];
  bit   q_mut[$];
  bit   q_sat[$];
  int   wr_addr_seen, wr_din_seen;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: counters updated in request order with saturating arithmetic.
  task automatic model_op(input int set, input int op, output ent_t r);
    int old;
    old = cnt_m[set];
    r.v = 1'b1; r.set = set; r.op = op; r.sat = 1'b0; r.newv = old;
    case (op)
      1: if (old == CMAX) r.sat = 1'b1; else r.newv = old + 1;
      2: if (old == 0) r.sat = 1'b1; else r.newv = old - 1;
      3: r.newv = 0;
      default: r.newv = old;
    endcase
    r.mut = (r.newv >= THR);
    cnt_m[set] = r.newv;
  endtask

  // One clock: drive at negedge, check SRAM ports, advance model at posedge, check outputs.
  task automatic step(input bit v, input int set, input int op);
    bit   ready;
    ent_t n;
    ready     = (init_cnt >= DEPTH);
    req_valid = v;
    req_set   = AW'(set);
    req_op    = 2'(op);
    #1;
    chk("req_ready", req_ready, ready);
    chk("csb1", sram_csb1, !(v && ready));
    if (v && ready) chk("addr1", sram_addr1, set);
    if (!ready) begin
      chk("init_csb0", sram_csb0, 0);
      chk("init_addr0", sram_addr0, init_cnt);
      chk("init_din0", sram_din0, INITV);
    end else if (d1.v && d1.op != 0) begin
      chk("wr_csb0", sram_csb0, 0);
      chk("wr_addr0", sram_addr0, d1.set);
      chk("wr_din0", sram_din0, d1.newv);
    end else begin
      chk("idle_csb0", sram_csb0, 1);
    end
    if (!sram_csb0) begin
      wr_addr_seen = int'(sram_addr0);
      wr_din_seen  = int'(sram_din0);
    end
    @(posedge clk);
    if (!ready) begin
      cnt_m[init_cnt] = INITV;
      init_cnt++;
    end
    if (d2.v && d2.sat && sat_ev_m < 65535) sat_ev_m++;
    d2   = d1;
    d1.v = 1'b0;
    if (v && ready) begin
      model_op(set, op, n);
      d1 = n;
    end
    @(negedge clk);
    chk("resp_valid", resp_valid, d2.v);
    if (d2.v) begin
      chk("resp_set", resp_set, d2.set);
      chk("resp_count", resp_count, d2.newv);
      chk("resp_mutate", resp_mutate, d2.mut);
      chk("resp_sat", resp_sat, d2.sat);
    end
    if (resp_valid) begin
      q_cnt.push_back(int'(resp_count));
      q_mut.push_back(resp_mutate);
      q_sat.push_back(resp_sat);
    end
    chk("init_done", init_done, init_cnt >= DEPTH);
`ifdef CNT_SAT_STATS_EN
    chk("sat_events", sat_events, sat_ev_m);
`endif
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  task automatic clear_log();
    q_cnt.delete();
    q_mut.delete();
    q_sat.delete();
  endtask

  // Assert reset at a negedge and check that everything drops at once.
  task automatic do_reset(input int hold);
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_csb1", sram_csb1, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_req_ready", req_ready, 0);
`ifdef CNT_SAT_STATS_EN
    chk("rst_sat_events", sat_events, 0);
`endif
    d1.v = 1'b0;
    d2.v = 1'b0;
    init_cnt = 0;
    sat_ev_m = 0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c [8];
    int exp_m [8];
    int exp_s [8];
    int exp_ab [4];
    exp_c  = '{1, 2, 3, 4, 5, 6, 7, 7};
    exp_m  = '{0, 0, 0, 0, 0, 1, 1, 1};
    exp_s  = '{0, 0, 0, 0, 0, 0, 0, 1};
    exp_ab = '{1, 1, 2, 2};

    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_op = '0;
    d1.v = 1'b0; d2.v = 1'b0; init_cnt = 0; sat_ev_m = 0;
    wr_addr_seen = -1; wr_din_seen = -1;
    @(negedge clk);
    do_reset(3);

    // Init sweep with no requests.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 0, 0);
      if (i == DEPTH - 2) chk("init_done_before_last", init_done, 0);
    end
    chk("init_done_after_sweep", init_done, 1);
    chk("sweep_last_addr", wr_addr_seen, 255);

    // Single increment.
    clear_log();
    step(1'b1, 'h12, 1);
    drain(1);
    chk("inc12_wr_addr", wr_addr_seen, 'h12);
    chk("inc12_wr_din", wr_din_seen, 1);
    chk("inc12_nresp", q_cnt.size(), 1);
    if (q_cnt.size() == 1) begin
      chk("inc12_count", q_cnt[0], 1);
      chk("inc12_mutate", q_mut[0], 0);
      chk("inc12_sat", q_sat[0], 0);
    end
    drain(1);

    // Back-to-back increments to saturation on one set.
    clear_log();
    for (int i = 0; i < 8; i++) step(1'b1, 'h40, 1);
    drain(2);
    chk("b2b_nresp", q_cnt.size(), 8);
    for (int i = 0; i < 8 && i < q_cnt.size(); i++) begin
      chk("b2b_count", q_cnt[i], exp_c[i]);
      chk("b2b_mutate", q_mut[i], exp_m[i]);
      chk("b2b_sat", q_sat[i], exp_s[i]);
    end

    // Decrement at zero saturates.
    clear_log();
    step(1'b1, 'h05, 2);
    drain(2);
    chk("dec0_nresp", q_cnt.size(), 1);
    if (q_cnt.size() == 1) begin
      chk("dec0_count", q_cnt[0], 0);
      chk("dec0_sat", q_sat[0], 1);
    end

    // Clear a saturated set.
    clear_log();
    step(1'b1, 'h40, 3);
    drain(1);
    chk("clr_wr_addr", wr_addr_seen, 'h40);
    chk("clr_wr_din", wr_din_seen, 0);
    drain(1);
    chk("clr_nresp", q_cnt.size(), 1);
    if (q_cnt.size() == 1) chk("clr_count", q_cnt[0], 0);

    // Interleaved sets must not cross-forward.
    clear_log();
    for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? 'h21 : 'h22, 1);
    drain(2);
    chk("ab_nresp", q_cnt.size(), 4);
    for (int i = 0; i < 4 && i < q_cnt.size(); i++) chk("ab_count", q_cnt[i], exp_ab[i]);

    // Random burst over a few sets to stress forwarding, plus occasional wide sets.
    for (int i = 0; i < 1500; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      if (s == 'h30) s = 'h31;
      step($urandom_range(0, 3) != 0, s, int'($urandom_range(0, 3)));
    end
    drain(2);

    // Reset in the middle of a burst.
    clear_log();
    step(1'b1, 'h30, 1);
    drain(2);
    chk("pre_rst_nresp", q_cnt.size(), 1);
    if (q_cnt.size() == 1) chk("pre_rst_count", q_cnt[0], 1);
    step(1'b1, 'h30, 1);
    step(1'b1, 'h31, 1);
    chk("inflight_resp_valid", resp_valid, 1);
    chk("inflight_csb0", sram_csb0, 0);
    do_reset(2);
    chk("post_rst_addr0", sram_addr0, 0);
    for (int i = 0; i < DEPTH; i++)
      step($urandom_range(0, 1) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    chk("resweep_done", init_done, 1);

    clear_log();
    step(1'b1, 'h30, 0);
    drain(2);
    chk("post_rst_nresp", q_cnt.size(), 1);
    if (q_cnt.size() == 1) chk("post_rst_count", q_cnt[0], INITV);

    // Short random tail after the re-sweep.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
